axis_packet_fifo: RTL and testbench

Parametrised successor of the single-stream axis FIFO. It buffers up to DEPTH words plus a last-word flag between two valid/ready stream interfaces, and all outputs are registered. An optional packet mode holds words back until a complete packet (terminated by ilast) is stored. It also reports fill level, complete-packet count and a programmable almost-full flag for upstream flow control.

---
 rtl/axis_packet_fifo.sv | 233 +++++++++++++++++++++++
 tb/tb_axis_packet_fifo.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_fifo.sv
// -----------------------------------------------------------------------------
// axis_packet_fifo
//
// Purpose
//   Synchronous FIFO between two valid/ready streams. Each entry is a data
//   word plus a last-of-packet flag. All outputs come straight from flops.
//   In stream mode (PACKET=0) a word is offered downstream as soon as it is
//   stored. In packet mode (PACKET=1) a packet is held back until its last
//   word is stored (store-and-forward). If a single packet fills the whole
//   buffer, it is released early (cut-through) so that the FIFO cannot
//   deadlock. The block also reports fill level, the number of complete
//   packets held and an almost-full flag.
//
// Parameters
//   WIDTH       data width in bits (>= 1)
//   DEPTH       capacity in words (>= 2, need not be a power of two)
//   PACKET      0 = stream mode, 1 = packet (store-and-forward) mode
//   AFULL       almost-full threshold in words (1..DEPTH)
//   SIZE_WIDTH  width of the size / packets counters
//
// Ports
//   clock    in   single clock, all state changes on the rising edge
//   resetn   in   asynchronous active-low reset
//   idata    in   input word
//   ilast    in   input word ends a packet (sampled only when a word is taken)
//   ivalid   in   input word valid
//   iready   out  FIFO will take a word at the next edge (registered)
//   odata    out  head word (registered)
//   olast    out  last flag of the head word (registered)
//   ovalid   out  head word may be taken (registered)
//   oready   in   downstream takes the head word
//   size     out  number of stored words, including the one on odata
//   packets  out  number of complete packets stored
//   afull    out  size >= AFULL (registered)
// -----------------------------------------------------------------------------
module axis_packet_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int PACKET     = 0,
    parameter int AFULL      = DEPTH - 2,
    parameter int SIZE_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  resetn,

    input  logic [WIDTH-1:0]      idata,
    input  logic                  ilast,
    input  logic                  ivalid,
    output logic                  iready,

    output logic [WIDTH-1:0]      odata,
    output logic                  olast,
    output logic                  ovalid,
    input  logic                  oready,

    output logic [SIZE_WIDTH-1:0] size,
    output logic [SIZE_WIDTH-1:0] packets,
    output logic                  afull
);

    // -------------------------------------------------------------------------
    // Local constants and types
    // -------------------------------------------------------------------------
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_WIDTH-1:0]  LAST_PTR = PTR_WIDTH'(DEPTH - 1);
    localparam logic [SIZE_WIDTH-1:0] DEPTH_S  = SIZE_WIDTH'(DEPTH);
    localparam logic [SIZE_WIDTH-1:0] AFULL_S  = SIZE_WIDTH'(AFULL);

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } entry_t;

    // Pointers wrap explicitly at DEPTH-1 so that any DEPTH works, not only
    // powers of two.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_WIDTH'(1);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    entry_t                mem_q [DEPTH];

    logic [PTR_WIDTH-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [SIZE_WIDTH-1:0] size_q,    size_d;
    logic [SIZE_WIDTH-1:0] packets_q, packets_d;
    logic                  open_q,    open_d;
    logic                  iready_q,  iready_d;
    logic                  ovalid_q,  ovalid_d;
    logic                  afull_q,   afull_d;
    logic [WIDTH-1:0]      odata_q,   odata_d;
    logic                  olast_q,   olast_d;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    logic   itransfer;
    logic   otransfer;
    entry_t in_entry;

    assign itransfer = ivalid && iready_q;
    assign otransfer = ovalid_q && oready;
    assign in_entry  = '{last: ilast, data: idata};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic   head_load;
    entry_t head_next;

    always_comb begin
        // NOTE: combinational logic uses blocking '=' and gives every signal a
        // default at the top of the block, so no latch can be inferred.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        open_d    = open_q;
        odata_d   = odata_q;
        olast_d   = olast_q;
        head_load = 1'b0;
        head_next = '0;

        if (itransfer) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (otransfer) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        // Occupancy and complete-packet counters. Their increments and
        // decrements can cancel in the same cycle.
        size_d    = size_q
                  + SIZE_WIDTH'(itransfer)
                  - SIZE_WIDTH'(otransfer);
        packets_d = packets_q
                  + SIZE_WIDTH'(itransfer && ilast)
                  - SIZE_WIDTH'(otransfer && olast_q);

        // A packet is "open" once any non-last word of it has left. Its
        // remaining words must then flow as they arrive. Otherwise a
        // half-sent packet could stall behind the store-and-forward rule.
        if (PACKET != 0) begin
            if (otransfer) begin
                open_d = !olast_q;
            end
        end else begin
            open_d = 1'b0;
        end

        // Registered flags are computed from the post-edge occupancy, so
        // they describe the FIFO as it will be after this edge.
        iready_d = (size_d < DEPTH_S);
        afull_d  = (size_d >= AFULL_S);

        if (PACKET != 0) begin
            // Store-and-forward. The second term is the oversize guard: a
            // packet that fills the entire buffer can never see its last
            // word, so it is released cut-through.
            ovalid_d = ((size_d != '0) && ((packets_d != '0) || open_d))
                    || ((size_d == DEPTH_S) && (packets_d == '0));
        end else begin
            ovalid_d = (size_d != '0);
        end

        // The output register mirrors the head entry. It is reloaded only
        // when the head changes: the old head leaves, or an empty FIFO takes
        // its first word. If the new head is the word being written in this
        // same cycle, it bypasses storage.
        head_load = (size_d != '0) && (otransfer || (size_q == '0));
        head_next = (itransfer && (wr_ptr_q == rd_ptr_d)) ? in_entry
                                                           : mem_q[rd_ptr_d];
        if (head_load) begin
            odata_d = head_next.data;
            olast_d = head_next.last;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset. Pointers and counters define which
    // entries are valid, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (itransfer) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking '<=' only, so every flop samples
    // the values from before the edge regardless of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            size_q    <= '0;
            packets_q <= '0;
            open_q    <= 1'b0;
            iready_q  <= 1'b0;
            ovalid_q  <= 1'b0;
            afull_q   <= 1'b0;
            odata_q   <= '0;
            olast_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            size_q    <= size_d;
            packets_q <= packets_d;
            open_q    <= open_d;
            iready_q  <= iready_d;
            ovalid_q  <= ovalid_d;
            afull_q   <= afull_d;
            odata_q   <= odata_d;
            olast_q   <= olast_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign iready  = iready_q;
    assign ovalid  = ovalid_q;
    assign odata   = odata_q;
    assign olast   = olast_q;
    assign size    = size_q;
    assign packets = packets_q;
    assign afull   = afull_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_packet_fifo
//
// Three FIFO instances share one clock and one reset:
//   0: stream mode, DEPTH=4, AFULL=2
//   1: packet mode, DEPTH=4, AFULL=2
//   2: packet mode, DEPTH=5, AFULL=3 (non power-of-two depth)
// Each instance has a monitor. On every falling edge it compares the counters
// and flags against a reference queue. Words are pushed to the queue when they
// are accepted and popped and compared when they leave. Directed sequences add
// checks for latency and boundary conditions.
// -----------------------------------------------------------------------------
module tb_axis_packet_fifo;

    localparam int N_DUT = 3;

    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    logic [7:0] idata   [N_DUT];
    logic       ilast   [N_DUT];
    logic       ivalid  [N_DUT];
    logic       oready  [N_DUT];
    logic       iready  [N_DUT];
    logic [7:0] odata   [N_DUT];
    logic       olast   [N_DUT];
    logic       ovalid  [N_DUT];
    logic [2:0] size    [N_DUT];
    logic [2:0] packets [N_DUT];
    logic       afull   [N_DUT];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    axis_packet_fifo #(.WIDTH(8), .DEPTH(4), .PACKET(0), .AFULL(2), .SIZE_WIDTH(3)) dut_s (
        .clock(clock), .resetn(resetn),
        .idata(idata[0]), .ilast(ilast[0]), .ivalid(ivalid[0]), .iready(iready[0]),
        .odata(odata[0]), .olast(olast[0]), .ovalid(ovalid[0]), .oready(oready[0]),
        .size(size[0]), .packets(packets[0]), .afull(afull[0])
    );

    axis_packet_fifo #(.WIDTH(8), .DEPTH(4), .PACKET(1), .AFULL(2), .SIZE_WIDTH(3)) dut_p (
        .clock(clock), .resetn(resetn),
        .idata(idata[1]), .ilast(ilast[1]), .ivalid(ivalid[1]), .iready(iready[1]),
        .odata(odata[1]), .olast(olast[1]), .ovalid(ovalid[1]), .oready(oready[1]),
        .size(size[1]), .packets(packets[1]), .afull(afull[1])
    );

    axis_packet_fifo #(.WIDTH(8), .DEPTH(5), .PACKET(1), .AFULL(3), .SIZE_WIDTH(3)) dut_p5 (
        .clock(clock), .resetn(resetn),
        .idata(idata[2]), .ilast(ilast[2]), .ivalid(ivalid[2]), .iready(iready[2]),
        .odata(odata[2]), .olast(olast[2]), .ovalid(ovalid[2]), .oready(oready[2]),
        .size(size[2]), .packets(packets[2]), .afull(afull[2])
    );

    // High from the first rising edge after reset release. Before that edge,
    // iready is still at its reset value.
    logic up;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) up <= 1'b0;
        else         up <= 1'b1;
    end

    // -------------------------------------------------------------------------
    // Per-instance reference model and scoreboard
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < N_DUT; g++) begin : mon
        localparam int D  = (g == 2) ? 5 : 4;
        localparam int AF = (g == 2) ? 3 : 2;
        localparam bit PK = (g != 0);

        logic [8:0] q[$];
        bit         open;

        always @(negedge clock) begin
            int         pk;
            int         sz;
            bit         exp_ov;
            logic [8:0] e;
            if (!resetn) begin
                q.delete();
                open = 1'b0;
            end else if (up) begin
                sz = q.size();
                pk = 0;
                foreach (q[i]) if (q[i][8]) pk++;
                if (PK) exp_ov = ((sz > 0) && ((pk > 0) || open)) || ((sz == D) && (pk == 0));
                else    exp_ov = (sz > 0);
                check($sformatf("m%0d_size", g),    size[g],    sz);
                check($sformatf("m%0d_packets", g), packets[g], pk);
                check($sformatf("m%0d_afull", g),   afull[g],   sz >= AF);
                check($sformatf("m%0d_iready", g),  iready[g],  sz < D);
                check($sformatf("m%0d_ovalid", g),  ovalid[g],  exp_ov);
                if (ovalid[g] && oready[g] && (q.size() > 0)) begin
                    e = q.pop_front();
                    check($sformatf("m%0d_odata", g), odata[g], e[7:0]);
                    check($sformatf("m%0d_olast", g), olast[g], e[8]);
                    if (PK) open = !e[8];
                end
                if (ivalid[g] && iready[g]) q.push_back({ilast[g], idata[g]});
            end
        end
    end

    // -------------------------------------------------------------------------
    // Random traffic on one instance, then close the last packet and drain
    // -------------------------------------------------------------------------
    task automatic rand_run(input int k, input int n);
        int         sent = 0;
        int         cyc  = 0;
        bit         acc;
        logic [7:0] w = 8'(k * 64);
        while (sent < n && cyc < 45000) begin
            ivalid[k] = ($urandom_range(0, 1) == 1);
            idata[k]  = w;
            ilast[k]  = ($urandom_range(0, 3) == 0);
            oready[k] = ($urandom_range(0, 1) == 1);
            acc = ivalid[k] && iready[k];
            @(posedge clock); #1;
            cyc++;
            if (acc) begin
                sent++;
                w++;
            end
        end
        check($sformatf("rand%0d_sent", k), sent, n);
        // Terminate whatever packet is in flight so that packet mode can drain.
        oready[k] = 1'b1;
        ivalid[k] = 1'b1;
        ilast[k]  = 1'b1;
        idata[k]  = w;
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 20) begin
            acc = iready[k];
            @(posedge clock); #1;
            cyc++;
        end
        check($sformatf("rand%0d_close", k), acc, 1);
        ivalid[k] = 1'b0;
        ilast[k]  = 1'b0;
        cyc = 0;
        while (size[k] != 0 && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        check($sformatf("rand%0d_drained", k), size[k], 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Directed sequences
    // -------------------------------------------------------------------------
    initial begin
        logic [7:0] acc_q[$];
        logic [8:0] out_q[$];
        bit         acc;
        bit         seen;
        int         cyc;
        int         sent;

        resetn = 1'b0;
        for (int k = 0; k < N_DUT; k++) begin
            idata[k] = '0; ilast[k] = 1'b0; ivalid[k] = 1'b0; oready[k] = 1'b0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            check($sformatf("rst%0d_iready", k),  iready[k],  0);
            check($sformatf("rst%0d_ovalid", k),  ovalid[k],  0);
            check($sformatf("rst%0d_olast", k),   olast[k],   0);
            check($sformatf("rst%0d_odata", k),   odata[k],   0);
            check($sformatf("rst%0d_size", k),    size[k],    0);
            check($sformatf("rst%0d_packets", k), packets[k], 0);
            check($sformatf("rst%0d_afull", k),   afull[k],   0);
        end
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < N_DUT; k++) check($sformatf("rel%0d_iready", k), iready[k], 1);

        // ---- Stream fill with output stalled, then drain -------------------
        oready[0] = 1'b0;
        for (int v = 0; v < 6; v++) begin
            idata[0]  = 8'h10 + 8'(v);
            ivalid[0] = 1'b1;
            acc = iready[0];
            @(posedge clock); #1;
            if (acc) acc_q.push_back(8'h10 + 8'(v));
        end
        ivalid[0] = 1'b0;
        check("fill_accepted", acc_q.size(), 4);
        check("fill_last_word", acc_q[acc_q.size() - 1], 8'h13);
        check("fill_size", size[0], 4);
        check("fill_iready", iready[0], 0);
        check("fill_afull", afull[0], 1);
        check("fill_ovalid", ovalid[0], 1);
        check("fill_head", odata[0], 8'h10);
        oready[0] = 1'b1;
        cyc = 0;
        while (out_q.size() < 4 && cyc < 10) begin
            if (ovalid[0]) out_q.push_back({olast[0], odata[0]});
            @(posedge clock); #1;
            cyc++;
        end
        check("drain_count", out_q.size(), 4);
        for (int i = 0; i < out_q.size(); i++) check($sformatf("drain_word%0d", i), out_q[i][7:0], 8'h10 + 8'(i));
        check("drain_size", size[0], 0);
        check("drain_afull", afull[0], 0);

        // ---- Full-rate streaming -------------------------------------------
        for (int i = 0; i < 100; i++) begin
            idata[0]  = 8'(i);
            ivalid[0] = 1'b1;
            @(posedge clock); #1;
            check($sformatf("rate_ovalid%0d", i), ovalid[0], 1);
            check($sformatf("rate_odata%0d", i),  odata[0],  8'(i));
            check($sformatf("rate_size%0d", i),   size[0],   1);
        end
        ivalid[0] = 1'b0;
        @(posedge clock); #1;
        check("rate_empty", size[0], 0);
        check("rate_ovalid_end", ovalid[0], 0);

        // ---- Packet hold: A, B, C(last) ------------------------------------
        begin
            logic [7:0] in_d   [6] = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00};
            bit         in_v   [6] = '{1, 1, 1, 0, 0, 0};
            bit         in_l   [6] = '{0, 0, 1, 0, 0, 0};
            bit         ex_ov  [6] = '{0, 0, 1, 1, 1, 0};
            logic [7:0] ex_d   [6] = '{8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'h00};
            bit         ex_l   [6] = '{0, 0, 0, 0, 1, 0};
            int         ex_pk  [6] = '{0, 0, 1, 1, 1, 0};
            oready[1] = 1'b1;
            for (int t = 0; t < 6; t++) begin
                idata[1]  = in_d[t];
                ivalid[1] = in_v[t];
                ilast[1]  = in_l[t];
                @(posedge clock); #1;
                check($sformatf("pkt_ovalid%0d", t),  ovalid[1],  ex_ov[t]);
                check($sformatf("pkt_packets%0d", t), packets[1], ex_pk[t]);
                if (ex_ov[t]) begin
                    check($sformatf("pkt_odata%0d", t), odata[1], ex_d[t]);
                    check($sformatf("pkt_olast%0d", t), olast[1], ex_l[t]);
                end
            end
        end

        // ---- Oversize packet: 6 words, no last -----------------------------
        out_q.delete();
        sent = 0;
        seen = 1'b0;
        cyc  = 0;
        oready[1] = 1'b1;
        ilast[1]  = 1'b0;
        while (out_q.size() < 6 && cyc < 60) begin
            idata[1]  = 8'h60 + 8'(sent);
            ivalid[1] = (sent < 6);
            acc = ivalid[1] && iready[1];
            if (ovalid[1] && oready[1]) out_q.push_back({olast[1], odata[1]});
            @(posedge clock); #1;
            cyc++;
            if (acc) sent++;
            if (ovalid[1] && !seen) begin
                seen = 1'b1;
                check("ovf_rise_size", size[1], 4);
            end
        end
        ivalid[1] = 1'b0;
        check("ovf_released", seen, 1);
        check("ovf_count", out_q.size(), 6);
        for (int i = 0; i < out_q.size(); i++) check($sformatf("ovf_word%0d", i), out_q[i][7:0], 8'h60 + 8'(i));

        // ---- Reset while a packet is partly sent ---------------------------
        // The oversize packet left without a last word, so its packet is still
        // open. Three more words therefore show up on ovalid at once.
        oready[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idata[1]  = 8'h71 + 8'(i);
            ivalid[1] = 1'b1;
            @(posedge clock); #1;
        end
        ivalid[1] = 1'b0;
        check("mid_size", size[1], 3);
        check("mid_ovalid_open", ovalid[1], 1);
        resetn = 1'b0;
        #1;
        check("arst_iready",  iready[1],  0);
        check("arst_ovalid",  ovalid[1],  0);
        check("arst_olast",   olast[1],   0);
        check("arst_odata",   odata[1],   0);
        check("arst_size",    size[1],    0);
        check("arst_packets", packets[1], 0);
        check("arst_afull",   afull[1],   0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;

        // Clean two-word packet afterwards. The first word must be held, which
        // shows the open flag was cleared by reset.
        oready[1] = 1'b1;
        idata[1] = 8'h81; ilast[1] = 1'b0; ivalid[1] = 1'b1;
        @(posedge clock); #1;
        check("post_hold", ovalid[1], 0);
        idata[1] = 8'h82; ilast[1] = 1'b1;
        out_q.delete();
        cyc = 0;
        while (out_q.size() < 2 && cyc < 10) begin
            if (ovalid[1] && oready[1]) out_q.push_back({olast[1], odata[1]});
            @(posedge clock); #1;
            ivalid[1] = 1'b0;
            ilast[1]  = 1'b0;
            cyc++;
        end
        check("post_count", out_q.size(), 2);
        if (out_q.size() == 2) begin
            check("post_w0", out_q[0], {1'b0, 8'h81});
            check("post_w1", out_q[1], {1'b1, 8'h82});
        end
        check("post_packets", packets[1], 0);

        // ---- Random backpressure -------------------------------------------
        fork
            rand_run(0, 5000);
            rand_run(2, 5000);
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
